// File: rtl/rs_alu_if.sv
// rs_alu_if: bus bundle for the ALU reservation station.
//   Dispatch side : i_dp_* (two slots), o_dp_rdy, o_free_cnt
//   Wakeup side   : i_ex_*_rrftag, i_exfin_*, i_exfin_*_res for alu/mul/ld/jal_jalr
//   Issue side    : o_issue_vld, i_issue_rdy, o_issue_payload/rrftag/src1/src2
// Modport slave is the reservation station, master is whoever drives it.
//
// Issue handshake: a transfer happens on a rising edge where o_issue_vld and
// i_issue_rdy are both high. While o_issue_vld=1 and i_issue_rdy=0 the offered
// entry stays put unless a lower-index entry becomes ready first.
// When o_issue_vld=0 the o_issue_* data is don't-care.
`ifndef RRF_ENT_SEL
`define RRF_ENT_SEL 6
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

interface rs_alu_if #(
    parameter int RS_DEPTH  = 8,
    parameter int PAYLOAD_W = 16
);
    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    logic                        i_dp_vld0, i_dp_vld1;
    logic [PAYLOAD_W-1:0]        i_dp_payload0, i_dp_payload1;
    logic [`RRF_ENT_SEL-1:0]     i_dp_rrftag0, i_dp_rrftag1;
    logic                        i_dp_src1_vld0, i_dp_src1_vld1;
    logic                        i_dp_src2_vld0, i_dp_src2_vld1;
    logic [`RV32_DATA_WIDTH-1:0] i_dp_src1_0, i_dp_src1_1;
    logic [`RV32_DATA_WIDTH-1:0] i_dp_src2_0, i_dp_src2_1;

    logic [`RRF_ENT_SEL-1:0]     i_ex_alu_rrftag, i_ex_mul_rrftag;
    logic [`RRF_ENT_SEL-1:0]     i_ex_ld_rrftag, i_ex_jal_jalr_rrftag;
    logic                        i_exfin_alu, i_exfin_mul, i_exfin_ld, i_exfin_jal_jalr;
    logic [`RV32_DATA_WIDTH-1:0] i_exfin_alu_res, i_exfin_mul_res;
    logic [`RV32_DATA_WIDTH-1:0] i_exfin_ld_res, i_exfin_jal_jalr_res;

    logic                        o_dp_rdy;
    logic [CNT_W-1:0]            o_free_cnt;
    logic                        o_issue_vld;
    logic                        i_issue_rdy;
    logic [PAYLOAD_W-1:0]        o_issue_payload;
    logic [`RRF_ENT_SEL-1:0]     o_issue_rrftag;
    logic [`RV32_DATA_WIDTH-1:0] o_issue_src1, o_issue_src2;

    modport master (
        output i_dp_vld0, i_dp_vld1, i_dp_payload0, i_dp_payload1,
               i_dp_rrftag0, i_dp_rrftag1,
               i_dp_src1_vld0, i_dp_src1_vld1, i_dp_src2_vld0, i_dp_src2_vld1,
               i_dp_src1_0, i_dp_src1_1, i_dp_src2_0, i_dp_src2_1,
               i_ex_alu_rrftag, i_ex_mul_rrftag, i_ex_ld_rrftag, i_ex_jal_jalr_rrftag,
               i_exfin_alu, i_exfin_mul, i_exfin_ld, i_exfin_jal_jalr,
               i_exfin_alu_res, i_exfin_mul_res, i_exfin_ld_res, i_exfin_jal_jalr_res,
               i_issue_rdy,
        input  o_dp_rdy, o_free_cnt, o_issue_vld,
               o_issue_payload, o_issue_rrftag, o_issue_src1, o_issue_src2
    );

    modport slave (
        input  i_dp_vld0, i_dp_vld1, i_dp_payload0, i_dp_payload1,
               i_dp_rrftag0, i_dp_rrftag1,
               i_dp_src1_vld0, i_dp_src1_vld1, i_dp_src2_vld0, i_dp_src2_vld1,
               i_dp_src1_0, i_dp_src1_1, i_dp_src2_0, i_dp_src2_1,
               i_ex_alu_rrftag, i_ex_mul_rrftag, i_ex_ld_rrftag, i_ex_jal_jalr_rrftag,
               i_exfin_alu, i_exfin_mul, i_exfin_ld, i_exfin_jal_jalr,
               i_exfin_alu_res, i_exfin_mul_res, i_exfin_ld_res, i_exfin_jal_jalr_res,
               i_issue_rdy,
        output o_dp_rdy, o_free_cnt, o_issue_vld,
               o_issue_payload, o_issue_rrftag, o_issue_src1, o_issue_src2
    );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: reservation station for the ALU pipe.
//   Holds up to RS_DEPTH ops, accepts up to two dispatches per cycle, captures
//   operands from the four execute-finish buses and issues the lowest-index
//   fully-ready entry each cycle.
// Ports:
//   i_clk   : clock, all state on the rising edge
//   i_rst   : synchronous active-high reset, drops every entry
//   i_flush : mispredict flush, drops every entry (beats dispatch/issue/wakeup)
//   bus     : rs_alu_if.slave (dispatch, exfin broadcast, issue)
`ifndef RRF_ENT_SEL
`define RRF_ENT_SEL 6
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

module rs_alu #(
    parameter int RS_DEPTH  = 8,
    parameter int PAYLOAD_W = 16
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_flush,
    rs_alu_if.slave bus
);
    localparam int IDX_W  = $clog2(RS_DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int TAG_W  = `RRF_ENT_SEL;
    localparam int DATA_W = `RV32_DATA_WIDTH;

    logic [RS_DEPTH-1:0]  r_busy;
    logic [RS_DEPTH-1:0]  r_s1v, r_s2v;
    logic [PAYLOAD_W-1:0] r_payload [RS_DEPTH];
    logic [TAG_W-1:0]     r_tag     [RS_DEPTH];
    logic [DATA_W-1:0]    r_src1    [RS_DEPTH];
    logic [DATA_W-1:0]    r_src2    [RS_DEPTH];

    // Finish buses packed with alu at index 0 (highest priority).
    logic [3:0]          w_ex_vld;
    logic [4*TAG_W-1:0]  w_ex_tag;
    logic [4*DATA_W-1:0] w_ex_res;

    assign w_ex_vld = {bus.i_exfin_jal_jalr, bus.i_exfin_ld, bus.i_exfin_mul, bus.i_exfin_alu};
    assign w_ex_tag = {bus.i_ex_jal_jalr_rrftag, bus.i_ex_ld_rrftag,
                       bus.i_ex_mul_rrftag, bus.i_ex_alu_rrftag};
    assign w_ex_res = {bus.i_exfin_jal_jalr_res, bus.i_exfin_ld_res,
                       bus.i_exfin_mul_res, bus.i_exfin_alu_res};

    // Operand forwarding: returns {vld, data}. A valid operand passes through;
    // a pending one is replaced by the highest-priority matching result.
    // The loop runs from jal_jalr down to alu so that alu is applied last.
    function automatic logic [DATA_W:0] fwd_opr(
        input logic              vld,
        input logic [DATA_W-1:0] val,
        input logic [3:0]        ex_vld,
        input logic [4*TAG_W-1:0]  ex_tag,
        input logic [4*DATA_W-1:0] ex_res
    );
        logic [DATA_W:0] res;
        res = {vld, val};
        if (!vld) begin
            for (int u = 3; u >= 0; u--) begin
                if (ex_vld[u] && (ex_tag[u*TAG_W +: TAG_W] == val[TAG_W-1:0])) begin
                    res = {1'b1, ex_res[u*DATA_W +: DATA_W]};
                end
            end
        end
        return res;
    endfunction

    // Wakeup candidates for stored entries.
    logic [DATA_W:0] w_wk1 [RS_DEPTH];
    logic [DATA_W:0] w_wk2 [RS_DEPTH];

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_wk1[i] = fwd_opr(r_s1v[i], r_src1[i], w_ex_vld, w_ex_tag, w_ex_res);
            w_wk2[i] = fwd_opr(r_s2v[i], r_src2[i], w_ex_vld, w_ex_tag, w_ex_res);
        end
    end

    // Dispatch operands after same-cycle capture.
    logic [DATA_W:0] w_dp1_0, w_dp2_0, w_dp1_1, w_dp2_1;

    assign w_dp1_0 = fwd_opr(bus.i_dp_src1_vld0, bus.i_dp_src1_0, w_ex_vld, w_ex_tag, w_ex_res);
    assign w_dp2_0 = fwd_opr(bus.i_dp_src2_vld0, bus.i_dp_src2_0, w_ex_vld, w_ex_tag, w_ex_res);
    assign w_dp1_1 = fwd_opr(bus.i_dp_src1_vld1, bus.i_dp_src1_1, w_ex_vld, w_ex_tag, w_ex_res);
    assign w_dp2_1 = fwd_opr(bus.i_dp_src2_vld1, bus.i_dp_src2_1, w_ex_vld, w_ex_tag, w_ex_res);

    // Occupancy, lowest two free entries and issue select, all from registered state.
    logic [CNT_W-1:0] w_busy_cnt, w_free_cnt;
    logic             w_dp_rdy;
    logic [IDX_W-1:0] w_free0, w_free1, w_sel;
    logic             w_found0, w_found1, w_sel_found;

    always_comb begin
        w_busy_cnt  = '0;
        w_free0     = '0;
        w_free1     = '0;
        w_found0    = 1'b0;
        w_found1    = 1'b0;
        w_sel       = '0;
        w_sel_found = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_busy_cnt = w_busy_cnt + CNT_W'(r_busy[i]);
            if (!r_busy[i]) begin
                if (!w_found0) begin
                    w_free0  = IDX_W'(i);
                    w_found0 = 1'b1;
                end else if (!w_found1) begin
                    w_free1  = IDX_W'(i);
                    w_found1 = 1'b1;
                end
            end
            if (!w_sel_found && r_busy[i] && r_s1v[i] && r_s2v[i]) begin
                w_sel       = IDX_W'(i);
                w_sel_found = 1'b1;
            end
        end
    end

    assign w_free_cnt = CNT_W'(RS_DEPTH) - w_busy_cnt;
    assign w_dp_rdy   = (w_free_cnt >= CNT_W'(2));

    // Slot1 takes the lowest free entry when slot0 is idle, else the second-lowest.
    logic             w_wr0, w_wr1, w_issue_fire;
    logic [IDX_W-1:0] w_idx1;

    assign w_wr0        = w_dp_rdy && bus.i_dp_vld0 && w_found0;
    assign w_idx1       = bus.i_dp_vld0 ? w_free1 : w_free0;
    assign w_wr1        = w_dp_rdy && bus.i_dp_vld1 && (bus.i_dp_vld0 ? w_found1 : w_found0);
    assign w_issue_fire = w_sel_found && bus.i_issue_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_busy <= '0;
            r_s1v  <= '0;
            r_s2v  <= '0;
        end else begin
            // Wakeup only for occupied entries; freed entries keep stale tags harmlessly.
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_busy[i]) begin
                    {r_s1v[i], r_src1[i]} <= w_wk1[i];
                    {r_s2v[i], r_src2[i]} <= w_wk2[i];
                end
            end
            // Issued and dispatched entries never coincide: dispatch only targets free entries.
            if (w_issue_fire) begin
                r_busy[w_sel] <= 1'b0;
            end
            if (w_wr0) begin
                r_busy[w_free0]    <= 1'b1;
                r_payload[w_free0] <= bus.i_dp_payload0;
                r_tag[w_free0]     <= bus.i_dp_rrftag0;
                {r_s1v[w_free0], r_src1[w_free0]} <= w_dp1_0;
                {r_s2v[w_free0], r_src2[w_free0]} <= w_dp2_0;
            end
            if (w_wr1) begin
                r_busy[w_idx1]    <= 1'b1;
                r_payload[w_idx1] <= bus.i_dp_payload1;
                r_tag[w_idx1]     <= bus.i_dp_rrftag1;
                {r_s1v[w_idx1], r_src1[w_idx1]} <= w_dp1_1;
                {r_s2v[w_idx1], r_src2[w_idx1]} <= w_dp2_1;
            end
        end
    end

    assign bus.o_dp_rdy        = w_dp_rdy;
    assign bus.o_free_cnt      = w_free_cnt;
    assign bus.o_issue_vld     = w_sel_found;
    assign bus.o_issue_payload = r_payload[w_sel];
    assign bus.o_issue_rrftag  = r_tag[w_sel];
    assign bus.o_issue_src1    = r_src1[w_sel];
    assign bus.o_issue_src2    = r_src2[w_sel];

endmodule

// File: tb/tb_rs_alu.sv
`ifndef RRF_ENT_SEL
`define RRF_ENT_SEL 6
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

module tb_rs_alu;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    rs_alu_if #(.RS_DEPTH(DEPTH), .PAYLOAD_W(16)) bus ();

    rs_alu #(.RS_DEPTH(DEPTH), .PAYLOAD_W(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The station as a bag of slots; each cycle: results wake pending operands,
    // the lowest ready slot leaves if the ALU takes it, new ops fill the lowest holes.
    typedef struct {
        bit          busy;
        logic [15:0] pl;
        logic [5:0]  tag;
        logic [31:0] s1, s2;
        bit          v1, v2;
    } ent_t;

    ent_t m [DEPTH];

    function automatic void lookup(inout bit v, inout logic [31:0] d);
        bit          ev [4];
        logic [5:0]  et [4];
        logic [31:0] er [4];
        ev = '{bus.i_exfin_alu, bus.i_exfin_mul, bus.i_exfin_ld, bus.i_exfin_jal_jalr};
        et = '{bus.i_ex_alu_rrftag, bus.i_ex_mul_rrftag, bus.i_ex_ld_rrftag, bus.i_ex_jal_jalr_rrftag};
        er = '{bus.i_exfin_alu_res, bus.i_exfin_mul_res, bus.i_exfin_ld_res, bus.i_exfin_jal_jalr_res};
        if (v) return;
        for (int u = 0; u < 4; u++) begin
            if (ev[u] && et[u] == d[5:0]) begin
                d = er[u];
                v = 1'b1;
                return;
            end
        end
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < DEPTH; i++)
            if (m[i].busy && m[i].v1 && m[i].v2) return i;
        return -1;
    endfunction

    function automatic int m_free();
        int n = DEPTH;
        for (int i = 0; i < DEPTH; i++) if (m[i].busy) n--;
        return n;
    endfunction

    function automatic ent_t mk(input logic [15:0] pl, input logic [5:0] tag,
                                input bit v1, input logic [31:0] s1,
                                input bit v2, input logic [31:0] s2);
        ent_t e;
        e.busy = 1'b1; e.pl = pl; e.tag = tag;
        e.v1 = v1; e.s1 = s1; e.v2 = v2; e.s2 = s2;
        lookup(e.v1, e.s1);
        lookup(e.v2, e.s2);
        return e;
    endfunction

    task automatic model_step();
        ent_t nx [DEPTH];
        int   holes [$];
        int   sel;
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
            return;
        end
        nx  = m;
        sel = m_sel();
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].busy) begin
                lookup(nx[i].v1, nx[i].s1);
                lookup(nx[i].v2, nx[i].s2);
            end else begin
                holes.push_back(i);
            end
        end
        if (sel >= 0 && bus.i_issue_rdy) nx[sel].busy = 1'b0;
        if (holes.size() >= 2) begin
            if (bus.i_dp_vld0)
                nx[holes.pop_front()] = mk(bus.i_dp_payload0, bus.i_dp_rrftag0,
                    bus.i_dp_src1_vld0, bus.i_dp_src1_0, bus.i_dp_src2_vld0, bus.i_dp_src2_0);
            if (bus.i_dp_vld1)
                nx[holes.pop_front()] = mk(bus.i_dp_payload1, bus.i_dp_rrftag1,
                    bus.i_dp_src1_vld1, bus.i_dp_src1_1, bus.i_dp_src2_vld1, bus.i_dp_src2_1);
        end
        m = nx;
    endtask

    task automatic check_model();
        int sel;
        sel = m_sel();
        chk("rnd_issue_vld", 32'(bus.o_issue_vld), 32'(sel >= 0));
        chk("rnd_free_cnt", 32'(bus.o_free_cnt), 32'(m_free()));
        chk("rnd_dp_rdy", 32'(bus.o_dp_rdy), 32'(m_free() >= 2));
        if (sel >= 0) begin
            chk("rnd_payload", 32'(bus.o_issue_payload), 32'(m[sel].pl));
            chk("rnd_rrftag", 32'(bus.o_issue_rrftag), 32'(m[sel].tag));
            chk("rnd_src1", bus.o_issue_src1, m[sel].s1);
            chk("rnd_src2", bus.o_issue_src2, m[sel].s2);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_dp_vld0 = 0; bus.i_dp_vld1 = 0;
        bus.i_dp_payload0 = '0; bus.i_dp_payload1 = '0;
        bus.i_dp_rrftag0 = '0; bus.i_dp_rrftag1 = '0;
        bus.i_dp_src1_vld0 = 0; bus.i_dp_src1_vld1 = 0;
        bus.i_dp_src2_vld0 = 0; bus.i_dp_src2_vld1 = 0;
        bus.i_dp_src1_0 = '0; bus.i_dp_src1_1 = '0;
        bus.i_dp_src2_0 = '0; bus.i_dp_src2_1 = '0;
        bus.i_exfin_alu = 0; bus.i_exfin_mul = 0; bus.i_exfin_ld = 0; bus.i_exfin_jal_jalr = 0;
        bus.i_ex_alu_rrftag = '0; bus.i_ex_mul_rrftag = '0;
        bus.i_ex_ld_rrftag = '0; bus.i_ex_jal_jalr_rrftag = '0;
        bus.i_exfin_alu_res = '0; bus.i_exfin_mul_res = '0;
        bus.i_exfin_ld_res = '0; bus.i_exfin_jal_jalr_res = '0;
        bus.i_issue_rdy = 0;
    endtask

    task automatic drive_dp(input int slot, input logic [15:0] pl, input logic [5:0] tag,
                            input bit v1, input logic [31:0] s1,
                            input bit v2, input logic [31:0] s2);
        if (slot == 0) begin
            bus.i_dp_vld0 = 1; bus.i_dp_payload0 = pl; bus.i_dp_rrftag0 = tag;
            bus.i_dp_src1_vld0 = v1; bus.i_dp_src1_0 = s1;
            bus.i_dp_src2_vld0 = v2; bus.i_dp_src2_0 = s2;
        end else begin
            bus.i_dp_vld1 = 1; bus.i_dp_payload1 = pl; bus.i_dp_rrftag1 = tag;
            bus.i_dp_src1_vld1 = v1; bus.i_dp_src1_1 = s1;
            bus.i_dp_src2_vld1 = v2; bus.i_dp_src2_1 = s2;
        end
    endtask

    task automatic drive_ex(input bit av, input logic [5:0] at, input logic [31:0] ar,
                            input bit mv, input logic [5:0] mt, input logic [31:0] mr,
                            input bit lv, input logic [5:0] lt, input logic [31:0] lr,
                            input bit jv, input logic [5:0] jt, input logic [31:0] jr);
        bus.i_exfin_alu = av; bus.i_ex_alu_rrftag = at; bus.i_exfin_alu_res = ar;
        bus.i_exfin_mul = mv; bus.i_ex_mul_rrftag = mt; bus.i_exfin_mul_res = mr;
        bus.i_exfin_ld = lv; bus.i_ex_ld_rrftag = lt; bus.i_exfin_ld_res = lr;
        bus.i_exfin_jal_jalr = jv; bus.i_ex_jal_jalr_rrftag = jt; bus.i_exfin_jal_jalr_res = jr;
    endtask

    // ---------------- dispatch-capture vectors ----------------
    typedef struct {
        bit          v1; logic [31:0] s1;
        bit          v2; logic [31:0] s2;
        bit av; logic [5:0] at; logic [31:0] ar;
        bit mv; logic [5:0] mt; logic [31:0] mr;
        bit lv; logic [5:0] lt; logic [31:0] lr;
        bit jv; logic [5:0] jt; logic [31:0] jr;
        bit          e_vld; logic [31:0] e1; logic [31:0] e2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int sel;
        vecs[0] = '{1, 32'h100, 0, 32'h9, 1, 6'd9, 32'h11, 0, 6'd0, 32'h0,
                    0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 1, 32'h100, 32'h11};
        vecs[1] = '{0, 32'h4, 1, 32'h2, 1, 6'd4, 32'hA, 1, 6'd4, 32'hB,
                    0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 1, 32'hA, 32'h2};
        vecs[2] = '{0, 32'h5, 0, 32'h6, 0, 6'd0, 32'h0, 1, 6'd5, 32'hB,
                    1, 6'd5, 32'hC, 1, 6'd6, 32'hD, 1, 32'hB, 32'hD};
        vecs[3] = '{0, 32'h7, 0, 32'h7, 0, 6'd0, 32'h0, 0, 6'd0, 32'h0,
                    1, 6'd7, 32'hC, 1, 6'd7, 32'hD, 1, 32'hC, 32'hC};
        vecs[4] = '{1, 32'h7, 0, 32'h8, 1, 6'd7, 32'hFF, 1, 6'd8, 32'h88,
                    0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 1, 32'h7, 32'h88};
        vecs[5] = '{0, 32'hA, 1, 32'h1, 1, 6'd11, 32'h5, 0, 6'd0, 32'h0,
                    0, 6'd0, 32'h0, 1, 6'd12, 32'h6, 0, 32'h0, 32'h0};

        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;

        // Reset state, then hold.
        chk("rst_issue_vld", 32'(bus.o_issue_vld), 32'd0);
        chk("rst_free_cnt", 32'(bus.o_free_cnt), 32'd8);
        chk("rst_dp_rdy", 32'(bus.o_dp_rdy), 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_issue_vld", 32'(bus.o_issue_vld), 32'd0);
            chk("hold_free_cnt", 32'(bus.o_free_cnt), 32'd8);
        end

        // Ready op issues the cycle after dispatch, freed the cycle after issue.
        drive_dp(0, 16'h0A1, 6'd1, 1, 32'd5, 1, 32'd7);
        bus.i_issue_rdy = 1;
        step();
        idle_inputs();
        bus.i_issue_rdy = 1;
        chk("d2i_issue_vld", 32'(bus.o_issue_vld), 32'd1);
        chk("d2i_src1", bus.o_issue_src1, 32'd5);
        chk("d2i_src2", bus.o_issue_src2, 32'd7);
        chk("d2i_payload", 32'(bus.o_issue_payload), 32'h0A1);
        chk("d2i_rrftag", 32'(bus.o_issue_rrftag), 32'd1);
        chk("d2i_free_cnt", 32'(bus.o_free_cnt), 32'd7);
        step();
        chk("d2i_freed", 32'(bus.o_free_cnt), 32'd8);
        chk("d2i_empty", 32'(bus.o_issue_vld), 32'd0);

        // Pending src1 tag 3 woken by mul; eligible only the cycle after broadcast.
        idle_inputs();
        drive_dp(0, 16'h0B2, 6'd2, 0, 32'd3, 1, 32'h22);
        bus.i_issue_rdy = 1;
        step();
        idle_inputs();
        bus.i_issue_rdy = 1;
        chk("wk_wait0", 32'(bus.o_issue_vld), 32'd0);
        step();
        chk("wk_wait1", 32'(bus.o_issue_vld), 32'd0);
        drive_ex(0, 0, 0, 1, 6'd3, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wk_same_cycle", 32'(bus.o_issue_vld), 32'd0);
        step();
        idle_inputs();
        chk("wk_issue_vld", 32'(bus.o_issue_vld), 32'd1);
        chk("wk_src1", bus.o_issue_src1, 32'hDEAD);
        chk("wk_src2", bus.o_issue_src2, 32'h22);
        bus.i_issue_rdy = 1;
        step();
        chk("wk_freed", 32'(bus.o_free_cnt), 32'd8);

        // Capture at dispatch, priority, vld operands untouched; each case cleared by flush.
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            drive_dp(0, 16'(16'h300 + k), 6'(k), vecs[k].v1, vecs[k].s1, vecs[k].v2, vecs[k].s2);
            drive_ex(vecs[k].av, vecs[k].at, vecs[k].ar, vecs[k].mv, vecs[k].mt, vecs[k].mr,
                     vecs[k].lv, vecs[k].lt, vecs[k].lr, vecs[k].jv, vecs[k].jt, vecs[k].jr);
            step();
            idle_inputs();
            chk($sformatf("vec%0d_vld", k), 32'(bus.o_issue_vld), 32'(vecs[k].e_vld));
            if (vecs[k].e_vld) begin
                chk($sformatf("vec%0d_src1", k), bus.o_issue_src1, vecs[k].e1);
                chk($sformatf("vec%0d_src2", k), bus.o_issue_src2, vecs[k].e2);
            end
            flush = 1;
            step();
            flush = 0;
            chk($sformatf("vec%0d_flushed", k), 32'(bus.o_free_cnt), 32'd8);
        end

        // Fill with never-ready ops down to one free entry.
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            drive_dp(0, 16'h400, 6'd0, 0, 32'd60, 1, 32'd0);
            drive_dp(1, 16'h401, 6'd1, 0, 32'd61, 1, 32'd0);
            step();
            chk("fill_free_cnt", 32'(bus.o_free_cnt), 32'(6 - 2 * c));
            chk("fill_dp_rdy", 32'(bus.o_dp_rdy), 32'd1);
        end
        idle_inputs();
        drive_dp(0, 16'h402, 6'd2, 0, 32'd62, 1, 32'd0);
        step();
        chk("full_free_cnt", 32'(bus.o_free_cnt), 32'd1);
        chk("full_dp_rdy", 32'(bus.o_dp_rdy), 32'd0);
        idle_inputs();
        drive_dp(0, 16'h403, 6'd3, 1, 32'd1, 1, 32'd1);
        step();
        idle_inputs();
        chk("full_refused_cnt", 32'(bus.o_free_cnt), 32'd1);
        chk("full_refused_vld", 32'(bus.o_issue_vld), 32'd0);
        flush = 1;
        step();
        flush = 0;
        chk("full_flushed", 32'(bus.o_free_cnt), 32'd8);

        // Four ready entries held by back-pressure, then flush beats dispatch.
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            drive_dp(0, 16'(16'h600 + 2 * c), 6'(20 + 2 * c), 1, 32'(100 + c), 1, 32'(200 + c));
            drive_dp(1, 16'(16'h601 + 2 * c), 6'(21 + 2 * c), 1, 32'(110 + c), 1, 32'(210 + c));
            step();
        end
        idle_inputs();
        chk("bp_free_cnt", 32'(bus.o_free_cnt), 32'd4);
        for (int c = 0; c < 3; c++) begin
            chk("bp_issue_vld", 32'(bus.o_issue_vld), 32'd1);
            chk("bp_payload", 32'(bus.o_issue_payload), 32'h600);
            chk("bp_src1", bus.o_issue_src1, 32'd100);
            step();
        end
        drive_dp(0, 16'h700, 6'd30, 1, 32'd1, 1, 32'd1);
        drive_dp(1, 16'h701, 6'd31, 1, 32'd1, 1, 32'd1);
        bus.i_issue_rdy = 1;
        flush = 1;
        step();
        flush = 0;
        idle_inputs();
        chk("flush_issue_vld", 32'(bus.o_issue_vld), 32'd0);
        chk("flush_free_cnt", 32'(bus.o_free_cnt), 32'd8);
        chk("flush_dp_rdy", 32'(bus.o_dp_rdy), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] v;
            idle_inputs();
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    logic [31:0] a, b;
                    a = $urandom; a[5:0] = 6'($urandom_range(0, 7));
                    b = $urandom; b[5:0] = 6'($urandom_range(0, 7));
                    drive_dp(s, 16'($urandom), 6'($urandom),
                             $urandom_range(0, 9) < 6, a, $urandom_range(0, 9) < 6, b);
                end
            end
            v = $urandom;
            drive_ex(v[0], 6'($urandom_range(0, 7)), $urandom,
                     v[1], 6'($urandom_range(0, 7)), $urandom,
                     v[2] & v[5], 6'($urandom_range(0, 7)), $urandom,
                     v[3] & v[6], 6'($urandom_range(0, 7)), $urandom);
            bus.i_issue_rdy = $urandom_range(0, 9) < 6;
            flush = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            flush = 0;
            rst = 0;
            check_model();
        end

        sel = m_sel();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
